// File: rtl/song_pkg.sv
// Shared definitions for the song playback path: sequencer states, default
// song length and the note indices understood by the note-selection mux.
package song_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int SONG_LEN_DEFAULT = 148;

    localparam int NOTE_MI      = 6;
    localparam int NOTE_SILENCE = 13;

endpackage

// File: rtl/step_prescaler.sv
// Step-length prescaler: counts clk cycles within a song step and reports the
// terminal count and the end-of-step gap window. Optional SONG_SEQUENCER_TEMPO_ADJ_EN.
module step_prescaler #(
    parameter int unsigned TICKS_PER_STEP = 12_500_000,
    parameter int unsigned GAP_TICKS      = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SONG_SEQUENCER_TEMPO_ADJ_EN
    input  logic [1:0] tempo_shift,
`endif
    input  logic       en,
    input  logic       clr,
    output logic       tc,
    output logic       gap_next
);

    localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    logic [CNT_W-1:0] count, count_next;
    logic [31:0]      len_cur, len_nx, gap_nx;

`ifdef SONG_SEQUENCER_TEMPO_ADJ_EN
    // The shift is latched only at step boundaries so a step never changes length.
    logic [1:0] shift_q, shift_next;

    assign shift_next = (clr || (en && tc)) ? tempo_shift : shift_q;
    assign len_cur    = 32'(TICKS_PER_STEP) >> shift_q;
    assign len_nx     = 32'(TICKS_PER_STEP) >> shift_next;
    assign gap_nx     = 32'(GAP_TICKS) >> shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shift_q <= 2'd0;
        else        shift_q <= shift_next;
    end
`else
    assign len_cur = 32'(TICKS_PER_STEP);
    assign len_nx  = 32'(TICKS_PER_STEP);
    assign gap_nx  = 32'(GAP_TICKS);
`endif

    assign tc = (32'(count) == len_cur - 32'd1);

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (en)
            count_next = tc ? '0 : count + CNT_W'(1);
    end

    assign gap_next = (32'(count_next) >= len_nx - gap_nx);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_next;
    end

endmodule

// File: rtl/song_sequencer.sv
// Tempo-driven step sequencer producing the note-mux step index with start,
// pause, stop, looping and articulation mute. Optional SONG_SEQUENCER_TEMPO_ADJ_EN.
module song_sequencer
    import song_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 12_500_000,
    parameter int unsigned GAP_TICKS      = 500_000,
    parameter int unsigned SONG_LEN       = SONG_LEN_DEFAULT,
    parameter int unsigned STEP_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SONG_SEQUENCER_TEMPO_ADJ_EN
    input  logic [1:0]        tempo_shift,
`endif
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [STEP_W-1:0] sel,
    output logic              mute,
    output logic              step_tick,
    output logic              playing,
    output logic              done
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);

    seq_state_t        state, state_next;
    logic [STEP_W-1:0] sel_next;
    logic              presc_en, presc_clr, presc_tc, gap_next;
    logic              tick_next, done_next, mute_next, playing_next;

    step_prescaler #(
        .TICKS_PER_STEP(TICKS_PER_STEP),
        .GAP_TICKS     (GAP_TICKS)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SONG_SEQUENCER_TEMPO_ADJ_EN
        .tempo_shift(tempo_shift),
`endif
        .en         (presc_en),
        .clr        (presc_clr),
        .tc         (presc_tc),
        .gap_next   (gap_next)
    );

    always_comb begin
        state_next = state;
        sel_next   = sel;
        presc_en   = 1'b0;
        presc_clr  = 1'b0;
        tick_next  = 1'b0;
        done_next  = 1'b0;
        if (stop) begin
            state_next = IDLE;
            sel_next   = '0;
            presc_clr  = 1'b1;
        end else if (start && (state == IDLE || state == DONE)) begin
            state_next = PLAY;
            sel_next   = '0;
            presc_clr  = 1'b1;
        end else begin
            case (state)
                PLAY:    if (pause) state_next = PAUSED;
                         else       presc_en   = 1'b1;
                // Resuming counts this cycle too, so a pause freezes exactly as long as it is held.
                PAUSED:  if (!pause) begin
                             state_next = PLAY;
                             presc_en   = 1'b1;
                         end
                default: ;
            endcase
            if (presc_en && presc_tc) begin
                tick_next = 1'b1;
                if (sel < LAST_STEP) begin
                    sel_next = sel + STEP_W'(1);
                end else if (loop_en) begin
                    sel_next = '0;
                end else begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
        end
    end

    // Registered outputs are computed from the next state so they align with it.
    assign mute_next    = (state_next == PLAY) ? gap_next : 1'b1;
    assign playing_next = (state_next == PLAY) || (state_next == PAUSED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            mute      <= 1'b1;
            step_tick <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            mute      <= mute_next;
            step_tick <= tick_next;
            playing   <= playing_next;
            done      <= done_next;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a position-based playback model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_song_sequencer;

    localparam int T = 4;
    localparam int G = 1;
    localparam int L = 5;

    typedef struct {
        logic [7:0] sel;
        logic       mute;
        logic       tick;
        logic       playing;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] sel;
    logic       mute, step_tick, playing, done;
`ifdef SONG_SEQUENCER_TEMPO_ADJ_EN
    logic [1:0] tempo_shift = 2'd0;
`endif

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t mon_e;

    // Model: whether a song is running, whether it is held, and how many
    // cycles have been played since the start of the current pass.
    bit m_run = 0;
    bit m_hold = 0;
    int m_pos = 0;

    song_sequencer #(
        .TICKS_PER_STEP(T),
        .GAP_TICKS     (G),
        .SONG_LEN      (L),
        .STEP_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SONG_SEQUENCER_TEMPO_ADJ_EN
        .tempo_shift(tempo_shift),
`endif
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop_en    (loop_en),
        .sel        (sel),
        .mute       (mute),
        .step_tick  (step_tick),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit s, input bit sp, input bit pa, input bit lp, output exp_t e);
        e.tick = 1'b0;
        e.done = 1'b0;
        if (sp) begin
            m_run = 0; m_hold = 0; m_pos = 0;
        end else if (s && !m_run) begin
            m_run = 1; m_hold = 0; m_pos = 0;
        end else if (m_run && pa) begin
            m_hold = 1;
        end else if (m_run) begin
            m_hold = 0;
            m_pos++;
            if (m_pos % T == 0) e.tick = 1'b1;
            if (m_pos == L * T) begin
                if (lp) m_pos = 0;
                else begin
                    m_run  = 0;
                    m_pos  = L * T - 1;
                    e.done = 1'b1;
                end
            end
        end
        e.sel     = 8'(m_pos / T);
        e.mute    = !m_run || m_hold || (m_pos % T >= T - G);
        e.playing = m_run;
    endtask

    task automatic cyc(input bit s, input bit sp, input bit pa, input bit lp);
        exp_t e;
        start   = s;
        stop    = sp;
        pause   = pa;
        loop_en = lp;
        model(s, sp, pa, lp, e);
        @(posedge clk);
        #1;
        sb.push_back(e);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("sel",       int'(sel),       int'(mon_e.sel));
            check("mute",      int'(mute),      int'(mon_e.mute));
            check("step_tick", int'(step_tick), int'(mon_e.tick));
            check("playing",   int'(playing),   int'(mon_e.playing));
            check("done",      int'(done),      int'(mon_e.done));
        end
    end

    initial begin
        int n;
        int ticks;
        int dones;
        bit p;
        bit lp;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel",     int'(sel),       0);
        check("rst_mute",    int'(mute),      1);
        check("rst_tick",    int'(step_tick), 0);
        check("rst_playing", int'(playing),   0);
        check("rst_done",    int'(done),      0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full non-looping song: done must land 20 cycles after PLAY entry.
        cyc(1, 0, 0, 0);
        n = 0;
        do begin
            cyc(0, 0, 0, 0);
            n++;
        end while (!done && n < 40);
        check("done_latency", n, L * T);
        repeat (4) cyc(0, 0, 0, 0);
        check("done_hold_sel", int'(sel), L - 1);

        // Looping: ticks keep coming and no done.
        cyc(1, 0, 0, 1);
        ticks = 0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0, 1);
            ticks += int'(step_tick);
            dones += int'(done);
        end
        check("loop_ticks", ticks, 7);
        check("loop_dones", dones, 0);

        // Pause for 7 cycles at phase 2 of step 1.
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        repeat (7) cyc(0, 0, 1, 0);
        check("pause_sel", int'(sel), 1);
        n = 0;
        do begin
            cyc(0, 0, 0, 0);
            n++;
        end while (!step_tick && n < 20);
        check("resume_tick_latency", n, 2);

        // start during PLAY is ignored; start+stop together goes idle.
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);

        // Asynchronous reset while playing step 3.
        cyc(1, 0, 0, 0);
        repeat (13) cyc(0, 0, 0, 0);
        check("pre_reset_sel", int'(sel), 3);
        #2 rst_n = 1'b0;
        sb.delete();
        m_run = 0; m_hold = 0; m_pos = 0;
        #1;
        check("async_rst_sel",     int'(sel),       0);
        check("async_rst_mute",    int'(mute),      1);
        check("async_rst_playing", int'(playing),   0);
        check("async_rst_tick",    int'(step_tick), 0);
        check("async_rst_done",    int'(done),      0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_sel",  int'(sel),  0);
        check("post_rst_mute", int'(mute), 1);

        // Randomized playback control.
        p  = 0;
        lp = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0)  p  = !p;
            if ($urandom_range(39) == 0) lp = !lp;
            cyc($urandom_range(24) == 0, $urandom_range(59) == 0, p, lp);
        end

        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Tempo-driven step sequencer that produces the 8-bit step index `sel` consumed by the note-selection mux. It replaces the free-running step counter with controlled playback: start, pause, stop, optional looping and end-of-song detection. It also produces a per-step articulation mute so that repeated notes are heard as separate notes.

Parameters:
- TICKS_PER_STEP, 12_500_000: clk cycles per song step (0.25 s at 50 MHz); must be ≥ 2.
- GAP_TICKS, 500_000: mute cycles at the end of each step; must be < TICKS_PER_STEP.
- SONG_LEN, 148: number of steps; `sel` runs 0..SONG_LEN-1; range 1..256.
- STEP_W, 8: width of `sel`.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse; begins playback from step 0.
- stop, input, 1: one-cycle pulse; aborts playback.
- pause, input, 1: level; freezes playback while high.
- loop_en, input, 1: level; wrap to step 0 at the end of the song instead of finishing.
- sel, output, STEP_W: current step index, driven to the mux.
- mute, output, 1: high means the downstream stage must output silence.
- step_tick, output, 1: one-cycle pulse on every step advance.
- playing, output, 1: high in PLAY and PAUSED.
- done, output, 1: one-cycle pulse when a non-looping song completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prescaler=0, sel=0, mute=1, step_tick=0, playing=0, done=0. Outputs are registered.
- States: IDLE, PLAY, PAUSED, DONE.
- Priority each cycle: stop > start > pause > counting.
- stop (any state): go to IDLE next cycle; sel=0, prescaler=0. stop and start in the same cycle: stop wins.
- start in IDLE or DONE: next cycle PLAY, sel=0, prescaler=0. start in PLAY or PAUSED: ignored.
- PLAY with pause=1: go to PAUSED; prescaler and sel hold. PAUSED with pause=0: return to PLAY and resume the count exactly where it stopped (no cycles lost or added).
- PLAY counting: prescaler counts 0..TICKS_PER_STEP-1. At the terminal count:
  - prescaler goes to 0 and step_tick=1 for one cycle;
  - if sel<SONG_LEN-1: sel+1;
  - else if loop_en=1: sel=0 and stay in PLAY (step_tick still fires);
  - else: go to DONE, done=1 for one cycle, sel holds at SONG_LEN-1.
- Step timing: each step lasts exactly TICKS_PER_STEP cycles. The first step_tick comes TICKS_PER_STEP cycles after the PLAY entry cycle.
- mute:
  - 1 in IDLE, PAUSED and DONE;
  - in PLAY, 1 when prescaler ≥ TICKS_PER_STEP-GAP_TICKS, else 0.
- loop_en is sampled only at the terminal count of the last step.
- Widths: prescaler width is $clog2(TICKS_PER_STEP). Comparisons are unsigned. sel never exceeds SONG_LEN-1.

Optional Feature:
- Macro: SONG_SEQUENCER_TEMPO_ADJ_EN.
- Defined: adds input tempo_shift[1:0]. Effective step length is TICKS_PER_STEP>>tempo_shift, and the gap is GAP_TICKS>>tempo_shift. tempo_shift is sampled when prescaler wraps to 0 and on PLAY entry, so a step never changes length mid-step.
- Undefined: no port is added and step length is fixed at TICKS_PER_STEP.

Decomposition:
- Package song_pkg holds:
  - the state enum seq_state_t (IDLE, PLAY, PAUSED, DONE);
  - SONG_LEN_DEFAULT;
  - the note-index localparams shared with the mux (NOTE_MI=6, NOTE_SILENCE=13, ...).
- One sub-module, step_prescaler: enable/clear inputs, terminal-count and gap-window outputs, parameterised by TICKS_PER_STEP and GAP_TICKS.
- The FSM and the sel counter stay in the top level.

Test Plan (bench uses TICKS_PER_STEP=4, GAP_TICKS=1, SONG_LEN=5):
- Reset mid-PLAY (rst_n low at sel=3) -> all outputs go to reset values immediately; after release, state=IDLE, sel=0, mute=1.
- start pulse, loop_en=0 -> sel steps 0,1,2,3,4 with 4 cycles each; step_tick fires 4 cycles after PLAY entry; mute=1 on the 4th cycle of each step; done pulses once at cycle 20; sel holds at 4; playing=0.
- loop_en=1 -> after sel=4, sel=0 with step_tick=1 and no done; playback continues.
- pause high for 7 cycles at prescaler=2 of sel=1 -> sel holds at 1 and mute=1; after release, next step_tick arrives 2 cycles later.
- start and stop in the same cycle while in PLAY -> IDLE, sel=0. start during PLAY -> no change to sel or prescaler.
- With SONG_SEQUENCER_TEMPO_ADJ_EN and tempo_shift=1 -> steps last 2 cycles. Changing tempo_shift mid-step -> takes effect on the next step only.
